pipeline_sequencer: RTL and testbench

Parametrised controller that sequences the generate -> encode -> bus -> decode -> count test pipeline for a burst of N data words. Each stage enable rises a fixed gap after the previous one and, unlike the fixed 5-state controller, drains the pipeline stage by stage. The stage count, inter-stage gap and burst length are all configurable. The block adds hold (stall), abort and a completed-word count, and sits at the top of the link testbench datapath, driving the enables of every pipeline block.

---
 rtl/pipeline_sequencer_if.sv | 27 ++
 rtl/pipeline_sequencer.sv | 80 ++++++++
 tb/tb_pipeline_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Handshake/status bundle between the burst sequencer and whoever requests bursts.
// master drives start/config/stall/abort; slave (the sequencer) drives enables and status.
interface pipeline_sequencer_if #(
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 11
);
   logic                  valid_in;
   logic [CNT_W-1:0]      cfg_words;
   logic                  hold;
   logic                  abort;
   logic [NUM_STAGES-1:0] stage_en;
   logic                  trigger;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic [CNT_W-1:0]      words_out;

   modport master (
      output valid_in, cfg_words, hold, abort,
      input  stage_en, trigger, busy, done, aborted, words_out
   );

   modport slave (
      input  valid_in, cfg_words, hold, abort,
      output stage_en, trigger, busy, done, aborted, words_out
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Sequences generate->encode->bus->decode->count for an N-word burst: enables rise
// and fall in thermometer order through a delay line, with stall, abort and word count.
module pipeline_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int STAGE_GAP  = 1,
   parameter int CNT_W      = 11,
   parameter int TRIG_LEN   = 3
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_sequencer_if.slave bus
);
   localparam int DL_LEN = (NUM_STAGES - 1) * STAGE_GAP;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      n_q, issue_cnt, words_q;
   logic [DL_LEN-1:0]     dl_q, dl_shift;
   logic [NUM_STAGES-1:0] stg;
   logic                  aborted_q;
   logic                  en0, kill, start;

   assign en0      = (state == ACTIVE);
   assign kill     = bus.abort && (state == ACTIVE || state == DRAIN);
   assign start    = (state == IDLE) && bus.valid_in;
   assign dl_shift = (dl_q << 1) | DL_LEN'(en0);

   // Stage k taps the delay line k*STAGE_GAP non-hold cycles behind stage 0.
   assign stg[0] = en0;
   for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stg
      assign stg[k] = dl_q[k*STAGE_GAP-1];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (bus.valid_in) state_nxt = (bus.cfg_words == '0) ? DONE : ACTIVE;
         ACTIVE: if (kill) state_nxt = IDLE;
                 else if (!bus.hold && (issue_cnt + CNT_W'(1) == n_q)) state_nxt = DRAIN;
         // Leave DRAIN when the shifted line would be empty, so done lands right after the last word.
         DRAIN:  if (kill) state_nxt = IDLE;
                 else if (!bus.hold && dl_shift == '0) state_nxt = DONE;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         n_q       <= '0;
         issue_cnt <= '0;
         words_q   <= '0;
         dl_q      <= '0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         aborted_q <= kill;
         if (kill)           dl_q <= '0;
         else if (!bus.hold) dl_q <= dl_shift;
         if (start) begin
            n_q       <= bus.cfg_words;
            issue_cnt <= '0;
            words_q   <= '0;
         end else if (!bus.hold && !kill) begin
            if (en0) issue_cnt <= issue_cnt + CNT_W'(1);
            if (stg[NUM_STAGES-1] && words_q != '1) words_q <= words_q + CNT_W'(1);
         end
      end
   end

   assign bus.stage_en  = stg;
   assign bus.trigger   = en0 && !bus.hold && (issue_cnt >= CNT_W'(1)) &&
                          (issue_cnt <= CNT_W'(TRIG_LEN));
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.aborted   = aborted_q;
   assign bus.words_out = words_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: closed-form enable windows per cycle plus a
// scoreboard of (done cycle, word count) pushed at start and popped on done.
module tb_pipeline_sequencer;
   localparam int NS = 5, G = 1, CW = 11, TL = 3;
   localparam int NSB = 3, GB = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipeline_sequencer_if #(.NUM_STAGES(NS),  .CNT_W(CW)) ifa();
   pipeline_sequencer_if #(.NUM_STAGES(NSB), .CNT_W(CW)) ifb();

   pipeline_sequencer #(.NUM_STAGES(NS), .STAGE_GAP(G), .CNT_W(CW), .TRIG_LEN(TL)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   pipeline_sequencer #(.NUM_STAGES(NSB), .STAGE_GAP(GB), .CNT_W(CW), .TRIG_LEN(TL)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));

   typedef struct {int done_rc; int words;} exp_t;
   exp_t sb[$];
   int ncmp = 0, nerr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   // One burst on dut_a; v is the count of edges that actually advanced the block.
   task automatic run_a(input int n, input int hf, input int ht, input bit keep_valid, input bit ab0);
      int hold_cnt, v, done_v, lim;
      exp_t e, got;
      hold_cnt  = 0;
      done_v    = (n == 0) ? 1 : n + (NS - 1) * G + 1;
      e.done_rc = done_v + ((hf >= 0) ? ht - hf + 1 : 0);
      e.words   = n;
      sb.push_back(e);
      lim = e.done_rc + 3;
      for (int rc = 0; rc <= lim; rc++) begin
         ifa.valid_in  = (rc == 0) || (keep_valid && rc < e.done_rc);
         ifa.cfg_words = CW'(n);
         ifa.hold      = (rc >= hf && rc <= ht);
         ifa.abort     = ab0 && (rc == 0);
         v = rc - hold_cnt;
         @(negedge clk);
         for (int k = 0; k < NS; k++)
            chk($sformatf("a.n%0d.en%0d@%0d", n, k, rc), 32'(ifa.stage_en[k]),
                32'((v >= 1 + k*G) && (v <= n + k*G)));
         chk($sformatf("a.n%0d.trig@%0d", n, rc), 32'(ifa.trigger),
             32'(!ifa.hold && v >= 2 && v <= TL + 1 && v <= n));
         chk($sformatf("a.n%0d.busy@%0d", n, rc), 32'(ifa.busy), 32'(v >= 1 && v <= done_v));
         chk($sformatf("a.n%0d.aborted@%0d", n, rc), 32'(ifa.aborted), 32'(0));
         if (ifa.done) begin
            if (sb.size() == 0) chk($sformatf("a.n%0d.extra_done@%0d", n, rc), 32'(ifa.done), 32'(0));
            else begin
               got = sb.pop_front();
               chk($sformatf("a.n%0d.done_cycle", n), 32'(rc), 32'(got.done_rc));
               chk($sformatf("a.n%0d.words_out", n), 32'(ifa.words_out), 32'(got.words));
            end
         end
         if (ifa.hold && rc >= 1) hold_cnt++;
         nxt();
      end
      if (sb.size() != 0) begin
         chk($sformatf("a.n%0d.done_timeout", n), 32'(sb.size()), 32'(0));
         sb.delete();
      end
      ifa.valid_in = 1'b0; ifa.hold = 1'b0; ifa.abort = 1'b0;
   endtask

   initial begin
      ifa.valid_in = 0; ifa.cfg_words = '0; ifa.hold = 0; ifa.abort = 0;
      ifb.valid_in = 0; ifb.cfg_words = '0; ifb.hold = 0; ifb.abort = 0;
      nxt(); nxt();
      @(negedge clk);
      chk("rst.a.en", 32'(ifa.stage_en), 32'(0));
      chk("rst.a.flags", 32'({ifa.trigger, ifa.busy, ifa.done, ifa.aborted}), 32'(0));
      chk("rst.a.words", 32'(ifa.words_out), 32'(0));
      chk("rst.b.en", 32'(ifb.stage_en), 32'(0));
      nxt();
      reset = 1'b0;

      run_a(4, -1, -1, 1'b0, 1'b0);

      // Three stages, gap 2, N=2: last stage in cycles 5-6, done in 7.
      for (int rc = 0; rc <= 9; rc++) begin
         ifb.valid_in  = (rc == 0);
         ifb.cfg_words = CW'(2);
         @(negedge clk);
         for (int k = 0; k < NSB; k++)
            chk($sformatf("b.en%0d@%0d", k, rc), 32'(ifb.stage_en[k]),
                32'(rc >= 1 + k*GB && rc <= 2 + k*GB));
         chk($sformatf("b.done@%0d", rc), 32'(ifb.done), 32'(rc == 7));
         chk($sformatf("b.busy@%0d", rc), 32'(ifb.busy), 32'(rc >= 1 && rc <= 7));
         nxt();
      end
      chk("b.words_out", 32'(ifb.words_out), 32'(2));

      run_a(4, 3, 5, 1'b0, 1'b0);   // stall mid-burst: done slips to 12
      run_a(0, -1, -1, 1'b0, 1'b0);  // empty burst, words_out cleared
      run_a(3, -1, -1, 1'b1, 1'b0);  // valid_in held through the burst
      run_a(2, -1, -1, 1'b0, 1'b1);  // abort alongside start in IDLE is ignored
      run_a(5, 6, 6, 1'b0, 1'b0);    // stall during drain

      // Abort mid-ACTIVE of a long burst.
      for (int rc = 0; rc <= 12; rc++) begin
         ifa.valid_in  = (rc == 0);
         ifa.cfg_words = CW'(100);
         ifa.abort     = (rc == 10);
         @(negedge clk);
         chk($sformatf("ab.done@%0d", rc), 32'(ifa.done), 32'(0));
         if (rc == 10) chk("ab.en@10", 32'(ifa.stage_en), 32'(5'h1f));
         if (rc == 11) begin
            chk("ab.en@11", 32'(ifa.stage_en), 32'(0));
            chk("ab.aborted@11", 32'(ifa.aborted), 32'(1));
            chk("ab.busy@11", 32'(ifa.busy), 32'(0));
         end
         if (rc == 12) chk("ab.aborted@12", 32'(ifa.aborted), 32'(0));
         nxt();
      end
      ifa.abort = 1'b0;

      // Reset in the middle of DRAIN, then a one-word burst.
      for (int rc = 0; rc <= 7; rc++) begin
         ifa.valid_in  = (rc == 0);
         ifa.cfg_words = CW'(4);
         reset         = (rc == 6);
         @(negedge clk);
         if (rc == 6) chk("rd.last_en@6", 32'(ifa.stage_en[NS-1]), 32'(1));
         if (rc == 7) begin
            chk("rd.en@7", 32'(ifa.stage_en), 32'(0));
            chk("rd.flags@7", 32'({ifa.trigger, ifa.busy, ifa.done, ifa.aborted}), 32'(0));
            chk("rd.words@7", 32'(ifa.words_out), 32'(0));
         end
         nxt();
      end
      run_a(1, -1, -1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
